n_cobs_tx_fifo: RTL and testbench

Byte FIFO directly downstream of the N-COBS encoder. It accepts 0..FifoEntryWidth bytes per cycle as a single packed write, and drains exactly one byte per handshake to the UART transmitter. Writes are atomic: all bytes of a write are stored, or none are. Provides level and sticky overflow status for CSR readback.

---
 rtl/n_cobs_tx_fifo_pkg.sv | 15 +
 rtl/n_cobs_tx_fifo.sv | 105 ++++++++++
 tb/tb_n_cobs_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n_cobs_tx_fifo_pkg.sv
// Shared sizing for the N-COBS encoder and its byte FIFO toward the UART.
// The entry-width constants are also used by the encoder.
package n_cobs_tx_fifo_pkg;

    localparam int FifoEntryWidth     = 8;
    localparam int FifoEntryWidthSize = $clog2(FifoEntryWidth) + 1;
    localparam int FifoEntryWidthBits = FifoEntryWidth * 8;

    localparam int FifoDepth   = 64;
    localparam int FifoPtrBits = $clog2(FifoDepth);

    typedef logic [FifoPtrBits:0]   FifoLevelT;
    typedef logic [FifoPtrBits-1:0] FifoRdPtrT;

endpackage

// File: rtl/n_cobs_tx_fifo.sv
// Byte FIFO between the N-COBS encoder (multi-byte atomic writes) and the UART
// transmitter (one byte per handshake), with level and drop status for CSRs.
module n_cobs_tx_fifo
    import n_cobs_tx_fifo_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [FifoEntryWidthBits-1:0] write_data,
    input  logic [FifoEntryWidthSize-1:0] write_width,
    input  logic                          write_enable,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [FifoPtrBits:0]          level,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [15:0]                   drop_count
);

    localparam int ByteIdxBits = (FifoEntryWidth > 1) ? $clog2(FifoEntryWidth) : 1;

    logic [7:0] mem_q [FifoDepth];

    FifoRdPtrT   wr_ptr_q, wr_ptr_d;
    FifoRdPtrT   rd_ptr_q, rd_ptr_d;
    FifoLevelT   level_q, level_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    FifoLevelT write_len;
    FifoLevelT space;
    logic      write_req;
    logic      accept;
    logic      reject;
    logic      pop;

    logic [7:0]                    in_bytes [FifoEntryWidth];
    logic [7:0]                    wr_byte  [FifoEntryWidth];
    FifoRdPtrT                     wr_idx   [FifoEntryWidth];
    logic [FifoEntryWidthSize-1:0] src_idx  [FifoEntryWidth];
    logic                          wr_en    [FifoEntryWidth];

    // Handshake: a byte leaves when tx_valid && tx_ready at a rising clk_i;
    // tx_data stays on the head byte until that happens.
    assign tx_valid   = (level_q != '0);
    assign tx_data    = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    // Space is judged on the registered level, so a same-cycle pop never makes room.
    assign write_len = FifoLevelT'(write_width);
    assign space     = FifoLevelT'(FifoDepth) - level_q;
    assign write_req = write_enable && (write_width != '0);
    assign accept    = write_req && (write_len <= space);
    assign reject    = write_req && !accept;
    assign pop       = tx_valid && tx_ready;

    // Slot wr_ptr+k takes input byte w-1-k, so the most significant valid byte goes out first.
    always_comb begin
        for (int k = 0; k < FifoEntryWidth; k++) begin
            in_bytes[k] = write_data[8*k +: 8];
            wr_en[k]    = accept && (FifoEntryWidthSize'(k) < write_width);
            wr_idx[k]   = wr_ptr_q + FifoRdPtrT'(k);
            src_idx[k]  = write_width - FifoEntryWidthSize'(k + 1);
            wr_byte[k]  = in_bytes[src_idx[k][ByteIdxBits-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < FifoEntryWidth; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_idx[k]] <= wr_byte[k];
            end
        end
    end

    always_comb begin
        wr_ptr_d     = accept ? wr_ptr_q + FifoRdPtrT'(write_width) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + FifoRdPtrT'(1) : rd_ptr_q;
        level_d      = level_q + (accept ? write_len : '0) - (pop ? FifoLevelT'(1) : '0);
        overflow_d   = reject ? 1'b1 : (overflow_clear ? 1'b0 : overflow_q);
        drop_count_d = drop_count_q;
        if (reject && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_n_cobs_tx_fifo.sv
// Directed bench for n_cobs_tx_fifo: ordering, pointer wrap, overflow, status and async reset.
module tb_n_cobs_tx_fifo;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] write_data;
    logic [3:0]  write_width;
    logic        write_enable;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [6:0]  level;
    logic        overflow;
    logic        overflow_clear;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int wr_seq   = 0;
    int rd_seq   = 0;

    n_cobs_tx_fifo dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .write_data     (write_data),
        .write_width    (write_width),
        .write_enable   (write_enable),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .drop_count     (drop_count)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i        = 1'b1;
        write_enable   = 1'b0;
        write_width    = '0;
        write_data     = '0;
        tx_ready       = 1'b0;
        overflow_clear = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Stream byte s carries value s[7:0]; the first byte in stream order sits in the top valid lane.
    task automatic push(input int w, input bit acc);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < w; k++) d[8*(w-1-k) +: 8] = 8'(wr_seq + k);
        write_data   = d;
        write_width  = 4'(w);
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        if (acc) wr_seq += w;
    endtask

    task automatic drain(input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(rd_seq)) begin
                failures++;
                $display("FAIL drain[%0d] tx_valid=%0b tx_data=%02h required valid=1 data=%02h",
                         i, tx_valid, tx_data, 8'(rd_seq));
            end
            rd_seq++;
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (level !== 7'd0) begin failures++; $display("FAIL reset_level got=%0d required=0", level); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b required=0", tx_valid); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b required=0", overflow); end
        checks++;
        if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count got=%0d required=0", drop_count); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        exp_b = '{8'hAA, 8'hBB, 8'hCC};
        tx_ready     = 1'b1;
        write_data   = 64'h0000_0000_00AA_BBCC;
        write_width  = 4'd3;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i] || level !== 7'(3 - i)) begin
                failures++;
                $display("FAIL single[%0d] valid=%0b data=%02h level=%0d required valid=1 data=%02h level=%0d",
                         i, tx_valid, tx_data, level, exp_b[i], 3 - i);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0 || level !== 7'd0) begin
            failures++;
            $display("FAIL single_empty valid=%0b level=%0d required valid=0 level=0", tx_valid, level);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_b [5];
        exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wr_seq = 0;
        rd_seq = 0;
        tx_ready = 1'b0;
        repeat (7) push(8, 1'b1);
        push(3, 1'b1);
        checks++;
        if (level !== 7'd59) begin failures++; $display("FAIL wrap_fill_level got=%0d required=59", level); end
        drain(59);
        tx_ready     = 1'b1;
        write_data   = 64'h0000_0011_2233_4455;
        write_width  = 4'd5;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                failures++;
                $display("FAIL wrap_byte[%0d] valid=%0b data=%02h required valid=1 data=%02h",
                         i, tx_valid, tx_data, exp_b[i]);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty tx_valid got=%0b required=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        wr_seq   = 0;
        rd_seq   = 0;
        tx_ready = 1'b0;
        repeat (7) push(8, 1'b1);
        push(4, 1'b1);
        checks++;
        if (level !== 7'd60) begin failures++; $display("FAIL ovf_fill_level got=%0d required=60", level); end
        push(5, 1'b0);
        checks++;
        if (level !== 7'd60 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            failures++;
            $display("FAIL ovf_reject level=%0d overflow=%0b drops=%0d required level=60 overflow=1 drops=1",
                     level, overflow, drop_count);
        end
        push(4, 1'b1);
        checks++;
        if (level !== 7'd64 || tx_valid !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_fit level=%0d valid=%0b overflow=%0b required level=64 valid=1 overflow=1",
                     level, tx_valid, overflow);
        end
    endtask

    task automatic test_simultaneous();
        checks++;
        if (tx_data !== 8'(rd_seq)) begin
            failures++;
            $display("FAIL sim_head got=%02h required=%02h", tx_data, 8'(rd_seq));
        end
        tx_ready = 1'b1;
        push(1, 1'b0);
        rd_seq++;
        tx_ready = 1'b0;
        checks++;
        if (level !== 7'd63 || drop_count !== 16'd2) begin
            failures++;
            $display("FAIL sim_push_pop level=%0d drops=%0d required level=63 drops=2", level, drop_count);
        end
        push(1, 1'b1);
        checks++;
        if (level !== 7'd64) begin failures++; $display("FAIL sim_refill level got=%0d required=64", level); end
    endtask

    task automatic test_stall();
        drain(62);
        checks++;
        if (level !== 7'd2) begin failures++; $display("FAIL stall_level got=%0d required=2", level); end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (tx_data !== 8'(rd_seq) || level !== 7'd2 || tx_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall[%0d] data=%02h level=%0d valid=%0b required data=%02h level=2 valid=1",
                         i, tx_data, level, tx_valid, 8'(rd_seq));
            end
        end
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL clear_only overflow got=%0b required=0", overflow); end
        repeat (7) push(8, 1'b1);
        push(6, 1'b1);
        checks++;
        if (level !== 7'd64) begin failures++; $display("FAIL refill_level got=%0d required=64", level); end
        overflow_clear = 1'b1;
        push(1, 1'b0);
        overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd3) begin
            failures++;
            $display("FAIL clear_vs_reject overflow=%0b drops=%0d required overflow=1 drops=3", overflow, drop_count);
        end
        drain(64);
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        push(7, 1'b1);
        checks++;
        if (level !== 7'd7) begin failures++; $display("FAIL areset_pre_level got=%0d required=7", level); end
        #3;
        reset_i = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || level !== 7'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL areset_mid valid=%0b level=%0d overflow=%0b drops=%0d required all zero",
                     tx_valid, level, overflow, drop_count);
        end
        #1;
        reset_i = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL areset_idle valid got=%0b required=0", tx_valid); end
        write_data   = 64'h0000_0000_0000_005A;
        write_width  = 4'd1;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h5A || level !== 7'd1) begin
            failures++;
            $display("FAIL areset_post valid=%0b data=%02h level=%0d required valid=1 data=5a level=1",
                     tx_valid, tx_data, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_simultaneous();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
